i2c_reg_seq: RTL and testbench

I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

---
 rtl/i2c_reg_seq_pkg.sv | 88 ++++++++
 rtl/i2c_reg_seq_if.sv | 20 ++
 rtl/wb_single_master.sv | 57 +++++
 rtl/i2c_reg_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_reg_seq.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_reg_seq_pkg.sv
// Shared definitions for the I2C register sequencer: I2C core register map,
// CR/SR bit positions, command bytes, FSM encoding and the per-byte step table.
package i2c_reg_seq_pkg;

    localparam logic [2:0] REG_PRERLO = 3'd0;
    localparam logic [2:0] REG_PRERHI = 3'd1;
    localparam logic [2:0] REG_CTR    = 3'd2;
    localparam logic [2:0] REG_TXR    = 3'd3;
    localparam logic [2:0] REG_RXR    = 3'd3;
    localparam logic [2:0] REG_CR     = 3'd4;
    localparam logic [2:0] REG_SR     = 3'd4;

    localparam int CR_STA = 7;
    localparam int CR_STO = 6;
    localparam int CR_RD  = 5;
    localparam int CR_WR  = 4;
    localparam int CR_ACK = 3;

    localparam int SR_RXACK = 7;
    localparam int SR_BUSY  = 6;
    localparam int SR_AL    = 5;
    localparam int SR_TIP   = 1;

    localparam logic [7:0] CTR_CORE_EN     = 8'h80;
    localparam logic [7:0] CMD_STA_WR      = (8'd1 << CR_STA) | (8'd1 << CR_WR);
    localparam logic [7:0] CMD_WR          = (8'd1 << CR_WR);
    localparam logic [7:0] CMD_WR_STO      = (8'd1 << CR_WR) | (8'd1 << CR_STO);
    localparam logic [7:0] CMD_RD_NACK_STO = (8'd1 << CR_RD) | (8'd1 << CR_ACK) | (8'd1 << CR_STO);
    localparam logic [7:0] CMD_STO         = (8'd1 << CR_STO);

    typedef enum logic [3:0] {
        ST_INIT      = 4'd0,
        ST_IDLE      = 4'd1,
        ST_LOAD_TX   = 4'd2,
        ST_CMD       = 4'd3,
        ST_POLL      = 4'd4,
        ST_CHECK     = 4'd5,
        ST_READ_RX   = 4'd6,
        ST_STOP      = 4'd7,
        ST_STOP_POLL = 4'd8,
        ST_DONE      = 4'd9
    } state_t;

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] cr;
    } byte_step_t;

    // Byte 3 only exists for reads: it has no TXR load, just the read/NACK/stop command.
    function automatic byte_step_t byte_step(input logic       rnw,
                                             input logic [1:0] idx,
                                             input logic [6:0] dev,
                                             input logic [7:0] reg_a,
                                             input logic [7:0] wdata);
        byte_step_t s;
        s.tx = 8'h00;
        s.cr = 8'h00;
        case (idx)
            2'd0: begin
                s.tx = {dev, 1'b0};
                s.cr = CMD_STA_WR;
            end
            2'd1: begin
                s.tx = reg_a;
                s.cr = CMD_WR;
            end
            2'd2: begin
                if (rnw) begin
                    s.tx = {dev, 1'b1};
                    s.cr = CMD_STA_WR;
                end else begin
                    s.tx = wdata;
                    s.cr = CMD_WR_STO;
                end
            end
            2'd3: begin
                s.tx = 8'h00;
                s.cr = CMD_RD_NACK_STO;
            end
            default: begin
                s.tx = 8'h00;
                s.cr = 8'h00;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/i2c_reg_seq_if.sv
// Wishbone link between the sequencer (master) and the I2C core (slave).
interface i2c_reg_seq_if;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic       wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wb_single_master.sv
// Single-access Wishbone master: one start launches one classic cycle, held
// until ack; ack/rdat report completion one cycle later.
module wb_single_master (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       we,
    input  logic [2:0] adr,
    input  logic [7:0] dat,
    output logic       ack,
    output logic [7:0] rdat,
    i2c_reg_seq_if.master bus
);
    logic       cyc_r;
    logic       we_r;
    logic [2:0] adr_r;
    logic [7:0] dat_r;
    logic       ack_r;
    logic [7:0] rdat_r;

    // Bus cycle engine; dropping cyc on ack guarantees the idle gap between accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_r  <= 1'b0;
            we_r   <= 1'b0;
            adr_r  <= 3'd0;
            dat_r  <= 8'h00;
            ack_r  <= 1'b0;
            rdat_r <= 8'h00;
        end else begin
            ack_r <= 1'b0;
            if (!cyc_r) begin
                if (start) begin
                    cyc_r <= 1'b1;
                    we_r  <= we;
                    adr_r <= adr;
                    dat_r <= dat;
                end
            end else if (bus.wb_ack_i) begin
                cyc_r  <= 1'b0;
                we_r   <= 1'b0;
                adr_r  <= 3'd0;
                dat_r  <= 8'h00;
                ack_r  <= 1'b1;
                rdat_r <= bus.wb_dat_i;
            end
        end
    end

    assign bus.wb_cyc_o = cyc_r;
    assign bus.wb_stb_o = cyc_r;
    assign bus.wb_we_o  = we_r;
    assign bus.wb_adr_o = adr_r;
    assign bus.wb_dat_o = dat_r;
    assign ack          = ack_r;
    assign rdat         = rdat_r;
endmodule

// File: rtl/i2c_reg_seq.sv
// Register-level I2C sequencer: initialises an I2C master core over Wishbone and
// then performs single-byte register writes/reads on request.
module i2c_reg_seq
    import i2c_reg_seq_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd99
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       req,
    input  logic       rnw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic [1:0] err,
    i2c_reg_seq_if.master wb
);
    state_t     state_r;
    logic       wait_r;
    logic       start_r;
    logic       cmd_we_r;
    logic [2:0] cmd_adr_r;
    logic [7:0] cmd_dat_r;
    logic [1:0] idx_r;
    logic       rnw_r;
    logic [6:0] dev_r;
    logic [7:0] reg_r;
    logic [7:0] wdata_r;
    logic       sr_rxack_r;
    logic       sr_al_r;
    logic       sr_tip_r;
    logic       busy_r;
    logic       done_r;
    logic [1:0] err_r;
    logic [7:0] rdata_r;
    logic       ack_s;
    logic [7:0] rdat_s;
    byte_step_t step_s;

    assign step_s = byte_step(rnw_r, idx_r, dev_r, reg_r, wdata_r);

    wb_single_master u_wb (
        .clk   (wb_clk_i),
        .rst_n (arst_i),
        .start (start_r),
        .we    (cmd_we_r),
        .adr   (cmd_adr_r),
        .dat   (cmd_dat_r),
        .ack   (ack_s),
        .rdat  (rdat_s),
        .bus   (wb)
    );

    // Sequencer FSM: each bus state launches one access (wait_r low) then waits for its ack
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_r    <= ST_INIT;
            wait_r     <= 1'b0;
            start_r    <= 1'b0;
            cmd_we_r   <= 1'b0;
            cmd_adr_r  <= 3'd0;
            cmd_dat_r  <= 8'h00;
            idx_r      <= 2'd0;
            rnw_r      <= 1'b0;
            dev_r      <= 7'd0;
            reg_r      <= 8'h00;
            wdata_r    <= 8'h00;
            sr_rxack_r <= 1'b0;
            sr_al_r    <= 1'b0;
            sr_tip_r   <= 1'b0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 2'b00;
            rdata_r    <= 8'h00;
        end else begin
            start_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    if (!wait_r) begin
                        start_r  <= 1'b1;
                        wait_r   <= 1'b1;
                        cmd_we_r <= 1'b1;
                        case (idx_r)
                            2'd0: begin
                                cmd_adr_r <= REG_PRERLO;
                                cmd_dat_r <= PRESCALE[7:0];
                            end
                            2'd1: begin
                                cmd_adr_r <= REG_PRERHI;
                                cmd_dat_r <= PRESCALE[15:8];
                            end
                            default: begin
                                cmd_adr_r <= REG_CTR;
                                cmd_dat_r <= CTR_CORE_EN;
                            end
                        endcase
                    end else if (ack_s) begin
                        wait_r <= 1'b0;
                        if (idx_r == 2'd2) begin
                            idx_r   <= 2'd0;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            idx_r <= idx_r + 2'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (req) begin
                        rnw_r   <= rnw;
                        dev_r   <= dev_addr;
                        reg_r   <= reg_addr;
                        wdata_r <= wdata;
                        err_r   <= 2'b00;
                        busy_r  <= 1'b1;
                        idx_r   <= 2'd0;
                        state_r <= ST_LOAD_TX;
                    end
                end
                ST_LOAD_TX: begin
                    if (!wait_r) begin
                        start_r   <= 1'b1;
                        wait_r    <= 1'b1;
                        cmd_we_r  <= 1'b1;
                        cmd_adr_r <= REG_TXR;
                        cmd_dat_r <= step_s.tx;
                    end else if (ack_s) begin
                        wait_r  <= 1'b0;
                        state_r <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!wait_r) begin
                        start_r   <= 1'b1;
                        wait_r    <= 1'b1;
                        cmd_we_r  <= 1'b1;
                        cmd_adr_r <= REG_CR;
                        cmd_dat_r <= step_s.cr;
                    end else if (ack_s) begin
                        wait_r  <= 1'b0;
                        state_r <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    if (!wait_r) begin
                        start_r   <= 1'b1;
                        wait_r    <= 1'b1;
                        cmd_we_r  <= 1'b0;
                        cmd_adr_r <= REG_SR;
                        cmd_dat_r <= 8'h00;
                    end else if (ack_s) begin
                        wait_r     <= 1'b0;
                        sr_rxack_r <= rdat_s[SR_RXACK];
                        sr_al_r    <= rdat_s[SR_AL];
                        sr_tip_r   <= rdat_s[SR_TIP];
                        state_r    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // Lost arbitration means the bus is no longer ours, so no stop is issued
                    if (sr_al_r) begin
                        err_r[1] <= 1'b1;
                        done_r   <= 1'b1;
                        state_r  <= ST_DONE;
                    end else if (sr_tip_r) begin
                        state_r <= ST_POLL;
                    end else if (rnw_r && (idx_r == 2'd3)) begin
                        state_r <= ST_READ_RX;
                    end else if (sr_rxack_r) begin
                        err_r[0] <= 1'b1;
                        state_r  <= ST_STOP;
                    end else if (!rnw_r && (idx_r == 2'd2)) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + 2'd1;
                        state_r <= (rnw_r && (idx_r == 2'd2)) ? ST_CMD : ST_LOAD_TX;
                    end
                end
                ST_READ_RX: begin
                    if (!wait_r) begin
                        start_r   <= 1'b1;
                        wait_r    <= 1'b1;
                        cmd_we_r  <= 1'b0;
                        cmd_adr_r <= REG_RXR;
                        cmd_dat_r <= 8'h00;
                    end else if (ack_s) begin
                        wait_r  <= 1'b0;
                        rdata_r <= rdat_s;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_STOP: begin
                    if (!wait_r) begin
                        start_r   <= 1'b1;
                        wait_r    <= 1'b1;
                        cmd_we_r  <= 1'b1;
                        cmd_adr_r <= REG_CR;
                        cmd_dat_r <= CMD_STO;
                    end else if (ack_s) begin
                        wait_r  <= 1'b0;
                        state_r <= ST_STOP_POLL;
                    end
                end
                ST_STOP_POLL: begin
                    if (!wait_r) begin
                        start_r   <= 1'b1;
                        wait_r    <= 1'b1;
                        cmd_we_r  <= 1'b0;
                        cmd_adr_r <= REG_SR;
                        cmd_dat_r <= 8'h00;
                    end else if (ack_s) begin
                        wait_r <= 1'b0;
                        if (rdat_s[SR_AL]) begin
                            err_r[1] <= 1'b1;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else if (!rdat_s[SR_BUSY]) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_INIT;
                    wait_r  <= 1'b0;
                    idx_r   <= 2'd0;
                    busy_r  <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;
    assign rdata = rdata_r;
endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq against a behavioural I2C-core Wishbone slave;
// expected bus traffic is queued at stimulus time and checked after each transfer.
module tb_i2c_reg_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       rnw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic [1:0] err;

    i2c_reg_seq_if bus();

    i2c_reg_seq #(.PRESCALE(16'd99)) dut (
        .wb_clk_i (clk),
        .arst_i   (rst_n),
        .req      (req),
        .rnw      (rnw),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
        .wb       (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_q[$];
    logic [11:0] obs_log [0:511];
    logic [8:0]  obs_wr   = 9'd0;
    logic [8:0]  obs_rd   = 9'd0;
    int          done_cnt = 0;

    logic [2:0] nack_byte = 3'd7;
    logic [2:0] al_byte   = 3'd7;
    logic [7:0] rx_byte   = 8'h3C;
    logic [2:0] tip_cnt;
    logic [2:0] busy_cnt;
    logic [2:0] byte_no;
    logic [2:0] cur_byte;

    // I2C core model: random wait states, TIP for two polls per command, Busy for two polls after stop
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wb_ack_i <= 1'b0;
            bus.wb_dat_i <= 8'h00;
            tip_cnt      <= 3'd0;
            busy_cnt     <= 3'd0;
            byte_no      <= 3'd0;
            cur_byte     <= 3'd7;
        end else begin
            bus.wb_ack_i <= 1'b0;
            if (done) begin
                byte_no  <= 3'd0;
                done_cnt <= done_cnt + 1;
            end
            if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i && ($urandom_range(3, 0) != 32'd0)) begin
                bus.wb_ack_i <= 1'b1;
                if (bus.wb_we_o) begin
                    obs_log[obs_wr] <= {1'b1, bus.wb_adr_o, bus.wb_dat_o};
                    obs_wr          <= obs_wr + 9'd1;
                    if (bus.wb_adr_o == 3'd4) begin
                        if (bus.wb_dat_o == 8'h40) begin
                            busy_cnt <= 3'd2;
                        end else begin
                            tip_cnt  <= 3'd2;
                            cur_byte <= byte_no;
                            byte_no  <= byte_no + 3'd1;
                        end
                    end
                end else if (bus.wb_adr_o == 3'd3) begin
                    bus.wb_dat_i    <= rx_byte;
                    obs_log[obs_wr] <= {1'b0, 3'd3, 8'h00};
                    obs_wr          <= obs_wr + 9'd1;
                end else begin
                    bus.wb_dat_i <= {(cur_byte == nack_byte), (busy_cnt != 3'd0), (cur_byte == al_byte),
                                     3'b000, ((tip_cnt != 3'd0) && (cur_byte != al_byte)), 1'b0};
                    if (tip_cnt != 3'd0) tip_cnt <= tip_cnt - 3'd1;
                    if (busy_cnt != 3'd0) busy_cnt <= busy_cnt - 3'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ent(input logic we, input logic [2:0] adr, input logic [7:0] dat);
        return {we, adr, dat};
    endfunction

    task automatic push_init();
        exp_q.push_back(ent(1'b1, 3'd0, 8'h63));
        exp_q.push_back(ent(1'b1, 3'd1, 8'h00));
        exp_q.push_back(ent(1'b1, 3'd2, 8'h80));
    endtask

    task automatic push_write(input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd);
        exp_q.push_back(ent(1'b1, 3'd3, {d, 1'b0}));
        exp_q.push_back(ent(1'b1, 3'd4, 8'h90));
        exp_q.push_back(ent(1'b1, 3'd3, ra));
        exp_q.push_back(ent(1'b1, 3'd4, 8'h10));
        exp_q.push_back(ent(1'b1, 3'd3, wd));
        exp_q.push_back(ent(1'b1, 3'd4, 8'h50));
    endtask

    task automatic compare_log(input string tag);
        while (exp_q.size() > 0) begin
            logic [11:0] e;
            e = exp_q.pop_front();
            if (obs_rd != obs_wr) begin
                check({tag, "_wb"}, 32'(obs_log[obs_rd]), 32'(e));
                obs_rd = obs_rd + 9'd1;
            end else begin
                checks++;
                failures++;
                $error("FAIL %s_wb_missing observed=none expected=0x%0h", tag, e);
            end
        end
        check({tag, "_wb_extra"}, 32'(obs_wr - obs_rd), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            got = (busy == 1'b0);
        end
        check({tag, "_idle"}, 32'(got), 32'd1);
    endtask

    task automatic launch(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd);
        @(negedge clk);
        rnw = r; dev_addr = d; reg_addr = ra; wdata = wd; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [1:0] e_err, input logic chk_rd, input logic [7:0] e_rd);
        bit got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            got = (done == 1'b1);
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_err"}, 32'(err), 32'(e_err));
        if (chk_rd) check({tag, "_rdata"}, 32'(rdata), 32'(e_rd));
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0;
        bit seen;
        rst_n = 1'b1; req = 1'b0; rnw = 1'b0; dev_addr = 7'd0; reg_addr = 8'h00; wdata = 8'h00;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);

        // initialisation after release
        push_init();
        rst_n = 1'b1;
        wait_idle("init");
        compare_log("init");

        // register write, slave ACKs
        push_write(7'h50, 8'h10, 8'hA5);
        launch(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done("wr", 2'b00, 1'b0, 8'h00);
        compare_log("wr");

        // register read returning 0x3C
        exp_q.push_back(ent(1'b1, 3'd3, 8'hA0));
        exp_q.push_back(ent(1'b1, 3'd4, 8'h90));
        exp_q.push_back(ent(1'b1, 3'd3, 8'h10));
        exp_q.push_back(ent(1'b1, 3'd4, 8'h10));
        exp_q.push_back(ent(1'b1, 3'd3, 8'hA1));
        exp_q.push_back(ent(1'b1, 3'd4, 8'h90));
        exp_q.push_back(ent(1'b1, 3'd4, 8'h68));
        exp_q.push_back(ent(1'b0, 3'd3, 8'h00));
        launch(1'b1, 7'h50, 8'h10, 8'h00);
        wait_done("rd", 2'b00, 1'b1, 8'h3C);
        compare_log("rd");

        // address NACK: stop issued, Busy polled, rdata kept from the read
        nack_byte = 3'd0;
        exp_q.push_back(ent(1'b1, 3'd3, 8'hA0));
        exp_q.push_back(ent(1'b1, 3'd4, 8'h90));
        exp_q.push_back(ent(1'b1, 3'd4, 8'h40));
        launch(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done("nack", 2'b01, 1'b1, 8'h3C);
        compare_log("nack");
        nack_byte = 3'd7;

        // arbitration lost on the second byte: no stop, single done
        al_byte = 3'd1;
        d0 = done_cnt;
        exp_q.push_back(ent(1'b1, 3'd3, 8'hA0));
        exp_q.push_back(ent(1'b1, 3'd4, 8'h90));
        exp_q.push_back(ent(1'b1, 3'd3, 8'h10));
        exp_q.push_back(ent(1'b1, 3'd4, 8'h10));
        launch(1'b0, 7'h50, 8'h10, 8'hA5);
        wait_done("al", 2'b10, 1'b0, 8'h00);
        repeat (10) @(negedge clk);
        check("al_done_count", 32'(done_cnt - d0), 32'd1);
        compare_log("al");
        al_byte = 3'd7;

        // req held high: back-to-back transfers with one idle cycle between
        push_write(7'h2A, 8'h01, 8'h5A);
        push_write(7'h2A, 8'h01, 8'h5A);
        @(negedge clk);
        rnw = 1'b0; dev_addr = 7'h2A; reg_addr = 8'h01; wdata = 8'h5A; req = 1'b1;
        wait_done("b2b_first", 2'b00, 1'b0, 8'h00);
        @(negedge clk);
        check("b2b_reaccept", 32'(busy), 32'd1);
        req = 1'b0;
        wait_done("b2b_second", 2'b00, 1'b0, 8'h00);
        compare_log("b2b");

        // reset while a bus access is in flight
        launch(1'b1, 7'h50, 8'h10, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.wb_stb_o == 1'b1);
        end
        check("mid_stb_seen", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_cyc", 32'(bus.wb_cyc_o), 32'd0);
        check("mid_stb", 32'(bus.wb_stb_o), 32'd0);
        check("mid_we", 32'(bus.wb_we_o), 32'd0);
        check("mid_adr", 32'(bus.wb_adr_o), 32'd0);
        check("mid_dat", 32'(bus.wb_dat_o), 32'd0);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_done", 32'(done), 32'd0);
        check("mid_err", 32'(err), 32'd0);
        check("mid_rdata", 32'(rdata), 32'd0);
        exp_q.delete();
        obs_rd = obs_wr;
        repeat (3) @(negedge clk);
        push_init();
        rst_n = 1'b1;
        wait_idle("reinit");
        compare_log("reinit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
